// File: rtl/instr_line_server_pkg.sv
// instr_line_server_pkg: shared line geometry, FSM states and the word-offset to bit-slice mapping
package instr_line_server_pkg;
    localparam int LINE_W = 256;
    localparam int WORD_W = 32;
    localparam int WORDS  = 8;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;
    // offset 0 sits in the MSBs, matching the cache's extraction order
    function automatic int word_lsb(input logic [2:0] off);
        return LINE_W - WORD_W * (int'(off) + 1);
    endfunction
endpackage

// File: rtl/instr_line_server_if.sv
// instr_line_server_if: line-fill request/response and word-load signals between the cache side and the server
interface instr_line_server_if;
    import instr_line_server_pkg::*;
    logic              mem_req;
    logic [31:0]       mem_address;
    logic [LINE_W-1:0] mem_data;
    logic              mem_valid;
    logic              busy;
    logic              load_en;
    logic [31:0]       load_addr;
    logic [31:0]       load_data;
    modport master (output mem_req, mem_address, load_en, load_addr, load_data,
                    input  mem_data, mem_valid, busy);
    modport slave  (input  mem_req, mem_address, load_en, load_addr, load_data,
                    output mem_data, mem_valid, busy);
endinterface

// File: rtl/instr_line_server_line_store.sv
// instr_line_server_line_store: zero-initialised line array with a word write port and a read-before-write line read port
module instr_line_server_line_store
    import instr_line_server_pkg::*;
#(
    parameter int LINE_BITS = 10
) (
    input  logic                 CLK,
    input  logic                 we,
    input  logic [LINE_BITS-1:0] waddr,
    input  logic [2:0]           woff,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [LINE_BITS-1:0] raddr,
    output logic [LINE_W-1:0]    rdata
);
    logic [LINE_W-1:0] mem [2**LINE_BITS] = '{default: '0};

    always_ff @(posedge CLK)
        if (we) mem[waddr][word_lsb(woff) +: WORD_W] <= wdata;

    // asynchronous read sees pre-edge contents, so a same-edge write returns old data
    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_line_server.sv
// instr_line_server: memory-side responder returning a full 256-bit line LATENCY cycles after a request
module instr_line_server
    import instr_line_server_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 10
) (
    input  logic CLK,
    input  logic RESET,
    instr_line_server_if.slave bus
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "instr_line_server: LATENCY %0d outside 1..15", LATENCY);
    end

    state_t               state;
    logic [3:0]           cnt;
    logic [LINE_BITS-1:0] idx;
    logic [LINE_W-1:0]    rdata;
    logic                 unused;

    assign unused = ^{bus.mem_address[31:LINE_BITS+5], bus.mem_address[4:0],
                      bus.load_addr[31:LINE_BITS+5], bus.load_addr[1:0]};

    instr_line_server_line_store #(.LINE_BITS(LINE_BITS)) u_store (
        .CLK   (CLK),
        .we    (bus.load_en),
        .waddr (bus.load_addr[LINE_BITS+4:5]),
        .woff  (bus.load_addr[4:2]),
        .wdata (bus.load_data),
        .raddr (idx),
        .rdata (rdata)
    );

    // RESP drops straight to IDLE when the request is already low, giving LATENCY+2 throughput
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            bus.mem_data  <= '0;
            bus.mem_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.mem_valid <= 1'b0;
            case (state)
                S_IDLE: if (bus.mem_req) begin
                    state    <= S_WAIT;
                    cnt      <= 4'(LATENCY - 1);
                    idx      <= bus.mem_address[LINE_BITS+4:5];
                    bus.busy <= 1'b1;
                end
                S_WAIT: if (cnt == 4'd0) begin
                    state         <= S_RESP;
                    bus.mem_data  <= rdata;
                    bus.mem_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                S_RESP: begin
                    state    <= bus.mem_req ? S_HOLD : S_IDLE;
                    bus.busy <= bus.mem_req;
                end
                default: if (!bus.mem_req) begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
endmodule
